fetch_pc_ctrl: RTL and testbench

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

---
 rtl/fetch_pc_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_pc_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer for a single-outstanding instruction SRAM port.
// It issues requests, squashes stale returns after redirects and holds a one-entry fetch buffer.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stallD,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic {
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] fly_pc;
    logic [31:0] fly_pc_n;
    logic        drop;
    logic        drop_n;
    logic        vld_n;
    logic [31:0] ifpc_n;
    logic [31:0] ifinst_n;
    logic        accept;
    logic        ret;
    logic        keep;

    // A full buffer that decode refuses blocks the next request.
    assign inst_req  = !rst && (state == S_REQ) && !(if_valid && stallD);
    assign inst_addr = pc;

    assign accept = inst_req && inst_addr_ok;
    assign ret    = (state == S_WAIT) && inst_data_ok;
    assign keep   = ret && !drop && !redirect_valid;

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        fly_pc_n = fly_pc;
        drop_n   = drop;
        vld_n    = if_valid;
        ifpc_n   = if_pc;
        ifinst_n = if_inst;

        unique case (state)
            S_REQ: begin
                if (accept) begin
                    state_n  = S_WAIT;
                    fly_pc_n = pc;
                    pc_n     = pc + 32'd4;
                    drop_n   = redirect_valid;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_n = S_REQ;
                    drop_n  = 1'b0;
                end else if (redirect_valid) begin
                    drop_n = 1'b1;
                end
            end
            default: state_n = S_REQ;
        endcase

        if (redirect_valid) begin
            pc_n = redirect_pc;
        end

        if (redirect_valid) begin
            vld_n = 1'b0;
        end else if (keep) begin
            vld_n    = 1'b1;
            ifpc_n   = fly_pc;
            ifinst_n = inst_rdata;
        end else if (!stallD) begin
            vld_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            fly_pc   <= '0;
            drop     <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            fly_pc   <= fly_pc_n;
            drop     <= drop_n;
            if_valid <= vld_n;
            if_pc    <= ifpc_n;
            if_inst  <= ifinst_n;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, reset corner and
// randomized traffic against a transaction-level reference model.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RPC = 32'hBFC00000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stallD;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    fetch_pc_ctrl #(.RESET_PC(RPC)) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .stallD(stallD),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_inst(if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rp;
        logic        st;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    vec_t tbl[16];

    typedef struct {
        logic [31:0] a;
        bit          sq;
    } fly_t;

    fly_t        q[$];
    logic [31:0] m_pc;
    logic        m_v;
    logic [31:0] m_ifpc;
    logic [31:0] m_inst;

    task automatic model_reset();
        q.delete();
        m_pc   = RPC;
        m_v    = 1'b0;
        m_ifpc = '0;
        m_inst = '0;
    endtask

    function automatic logic model_req();
        return (q.size() == 0) && !(m_v && stallD);
    endfunction

    task automatic model_edge();
        logic acc;
        logic kept;
        fly_t f;
        fly_t nf;
        acc  = model_req() && inst_addr_ok;
        kept = 1'b0;
        if (q.size() > 0 && inst_data_ok) begin
            f    = q.pop_front();
            kept = !f.sq && !redirect_valid;
        end else if (q.size() > 0 && redirect_valid) begin
            q[0].sq = 1'b1;
        end
        if (acc) begin
            nf.a  = m_pc;
            nf.sq = redirect_valid;
            q.push_back(nf);
        end
        if (redirect_valid) m_pc = redirect_pc;
        else if (acc) m_pc = m_pc + 32'd4;
        if (redirect_valid) begin
            m_v = 1'b0;
        end else if (kept) begin
            m_v    = 1'b1;
            m_ifpc = f.a;
            m_inst = inst_rdata;
        end else if (!stallD) begin
            m_v = 1'b0;
        end
    endtask

    task automatic idle_in();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stallD         = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = '0;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle_in();

        // rv rp st aok dok rd | req addr | v ifpc inst
        tbl[0]  = '{0, 0, 0, 1, 0, 0, 1, RPC, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 1, 32'h24080001, 0, 32'hBFC00004,
                    1, RPC, 32'h24080001};
        tbl[2]  = '{0, 0, 1, 1, 0, 0, 0, 32'hBFC00004,
                    1, RPC, 32'h24080001};
        tbl[3]  = '{0, 0, 1, 1, 0, 0, 0, 32'hBFC00004,
                    1, RPC, 32'h24080001};
        tbl[4]  = '{0, 0, 1, 1, 0, 0, 0, 32'hBFC00004,
                    1, RPC, 32'h24080001};
        tbl[5]  = '{0, 0, 0, 1, 0, 0, 1, 32'hBFC00004,
                    0, RPC, 32'h24080001};
        tbl[6]  = '{1, 32'h80001000, 0, 0, 1, 32'hDEADBEEF, 0, 32'hBFC00008,
                    0, RPC, 32'h24080001};
        tbl[7]  = '{0, 0, 0, 1, 0, 0, 1, 32'h80001000,
                    0, RPC, 32'h24080001};
        tbl[8]  = '{0, 0, 0, 0, 1, 32'h11111111, 0, 32'h80001004,
                    1, 32'h80001000, 32'h11111111};
        tbl[9]  = '{1, 32'h80001000, 0, 1, 0, 0, 1, 32'h80001004,
                    0, 32'h80001000, 32'h11111111};
        tbl[10] = '{0, 0, 0, 0, 1, 32'h22222222, 0, 32'h80001000,
                    0, 32'h80001000, 32'h11111111};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 32'h80001000,
                    0, 32'h80001000, 32'h11111111};
        tbl[12] = '{1, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 32'h80001000,
                    0, 32'h80001000, 32'h11111111};
        tbl[13] = '{0, 0, 0, 1, 0, 0, 1, 32'hFFFFFFFC,
                    0, 32'h80001000, 32'h11111111};
        tbl[14] = '{0, 0, 0, 0, 1, 32'h33333333, 0, 32'h00000000,
                    1, 32'hFFFFFFFC, 32'h33333333};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 32'h00000000,
                    0, 32'hFFFFFFFC, 32'h33333333};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_addr", inst_addr, RPC);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_ifpc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rp;
            stallD         = tbl[i].st;
            inst_addr_ok   = tbl[i].aok;
            inst_data_ok   = tbl[i].dok;
            inst_rdata     = tbl[i].rd;
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, inst_req}, {31'd0, tbl[i].ereq});
            chk($sformatf("v%0d_addr", i), inst_addr, tbl[i].eaddr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_ifpc", i), if_pc, tbl[i].epc);
            chk($sformatf("v%0d_inst", i), if_inst, tbl[i].einst);
        end

        // Reset pulse while a request is outstanding.
        @(negedge clk);
        idle_in();
        inst_addr_ok = 1'b1;
        @(posedge clk);
        #1;
        inst_addr_ok = 1'b0;
        chk("wait_req", {31'd0, inst_req}, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, inst_req}, 32'd0);
        chk("arst_addr", inst_addr, RPC);
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_ifpc", if_pc, 32'd0);
        @(negedge clk);
        rst          = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h55555555;
        #1;
        chk("post_req", {31'd0, inst_req}, 32'd1);
        chk("post_addr", inst_addr, RPC);
        @(posedge clk);
        #1;
        chk("post_valid", {31'd0, if_valid}, 32'd0);
        chk("post_inst", if_inst, 32'd0);

        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            idle_in();
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                chk("rnd_rst_req", {31'd0, inst_req}, 32'd0);
                chk("rnd_rst_valid", {31'd0, if_valid}, 32'd0);
                chk("rnd_rst_addr", inst_addr, RPC);
                @(negedge clk);
                rst = 1'b0;
            end
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = {$urandom, 2'b00} >> 0;
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC
                                                         : {redirect_pc[31:2], 2'b00};
            stallD         = ($urandom_range(0, 2) == 0);
            inst_addr_ok   = $urandom_range(0, 1) == 1;
            inst_data_ok   = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            inst_rdata     = $urandom;
            #1;
            chk("rnd_req", {31'd0, inst_req}, {31'd0, model_req()});
            chk("rnd_addr", inst_addr, m_pc);
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_valid", {31'd0, if_valid}, {31'd0, m_v});
            chk("rnd_ifpc", if_pc, m_ifpc);
            chk("rnd_inst", if_inst, m_inst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
